// File: rtl/mult_score_pkg.sv
// Shared types and width helpers for the multiplier candidate scorer.
package mult_score_pkg;

    localparam int unsigned N_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Error counter must hold 2^(2n), i.e. one more bit than the index
    function automatic int unsigned err_w(input int unsigned n);
        return 2 * n + 1;
    endfunction

    // Hamming sum must hold 2n * 2^(2n)
    function automatic int unsigned biterr_w(input int unsigned n);
        return 2 * n + $clog2(2 * n) + 1;
    endfunction

    function automatic int unsigned popcnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_candidate_scorer_if.sv
// Control, candidate operand/product and result signals of the scorer.
interface mult_candidate_scorer_if #(
    parameter int unsigned N = mult_score_pkg::N_DEFAULT
);
    import mult_score_pkg::*;

    localparam int unsigned PW  = 2 * N;
    localparam int unsigned ECW = err_w(N);
    localparam int unsigned BEW = biterr_w(N);

    logic           start;
    logic [N-1:0]   a_o;
    logic [N-1:0]   b_o;
    logic [PW-1:0]  p_i;
    logic           busy;
    logic           done;
    logic           pass;
    logic [ECW-1:0] err_count;
    logic [BEW-1:0] bit_err_sum;
    logic           first_fail_valid;
    logic [N-1:0]   first_fail_a;
    logic [N-1:0]   first_fail_b;

    modport master (
        output start, p_i,
        input  a_o, b_o, busy, done, pass, err_count, bit_err_sum,
               first_fail_valid, first_fail_a, first_fail_b
    );

    modport slave (
        input  start, p_i,
        output a_o, b_o, busy, done, pass, err_count, bit_err_sum,
               first_fail_valid, first_fail_a, first_fail_b
    );

endinterface

// File: rtl/popcount_xor.sv
// Combinational popcount of (a ^ b).
module popcount_xor
    import mult_score_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]              a,
    input  logic [W-1:0]              b,
    output logic [popcnt_w(W)-1:0]    count
);

    localparam int unsigned CW = popcnt_w(W);

    logic [W-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(W); i++) begin
            count = count + CW'(diff[i]);
        end
    end

endmodule

// File: rtl/mult_candidate_scorer.sv
// Exhaustive scorer for a combinational NxN multiplier candidate.
// Optional Hamming accumulator built when MULT_SCORER_BITERR_EN is defined.
module mult_candidate_scorer
    import mult_score_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mult_candidate_scorer_if.slave bus
);

    localparam int unsigned PW  = 2 * N;
    localparam int unsigned ECW = err_w(N);
`ifdef MULT_SCORER_BITERR_EN
    localparam int unsigned BEW = biterr_w(N);
    localparam int unsigned CW  = popcnt_w(PW);
`endif

    state_e         state, state_n;
    logic [PW-1:0]  idx, idx_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;
    logic           pass_q, pass_n;
    logic [ECW-1:0] err_q, err_n;
    logic           ffv_q, ffv_n;
    logic [N-1:0]   ffa_q, ffa_n;
    logic [N-1:0]   ffb_q, ffb_n;
`ifdef MULT_SCORER_BITERR_EN
    logic [BEW-1:0] bes_q, bes_n;
    logic [CW-1:0]  pc;
`endif

    logic [PW-1:0]  a_ext;
    logic [PW-1:0]  b_ext;
    logic [PW-1:0]  exp_p;
    logic           mismatch;
    logic           last_vec;

    // Reference product at full 2N width; operands come straight from idx
    assign a_ext    = PW'(idx[PW-1:N]);
    assign b_ext    = PW'(idx[N-1:0]);
    assign exp_p    = a_ext * b_ext;
    assign mismatch = (bus.p_i != exp_p);
    assign last_vec = (idx == {PW{1'b1}});

`ifdef MULT_SCORER_BITERR_EN
    popcount_xor #(
        .W (PW)
    ) u_popcount_xor (
        .a     (bus.p_i),
        .b     (exp_p),
        .count (pc)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            ffv_q  <= 1'b0;
            ffa_q  <= '0;
            ffb_q  <= '0;
`ifdef MULT_SCORER_BITERR_EN
            bes_q  <= '0;
`endif
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            busy_q <= busy_n;
            done_q <= done_n;
            pass_q <= pass_n;
            err_q  <= err_n;
            ffv_q  <= ffv_n;
            ffa_q  <= ffa_n;
            ffb_q  <= ffb_n;
`ifdef MULT_SCORER_BITERR_EN
            bes_q  <= bes_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        busy_n  = busy_q;
        done_n  = 1'b0;
        pass_n  = pass_q;
        err_n   = err_q;
        ffv_n   = ffv_q;
        ffa_n   = ffa_q;
        ffb_n   = ffb_q;
`ifdef MULT_SCORER_BITERR_EN
        bes_n   = bes_q;
`endif

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = SWEEP;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    pass_n  = 1'b0;
                    err_n   = '0;
                    ffv_n   = 1'b0;
                    ffa_n   = '0;
                    ffb_n   = '0;
`ifdef MULT_SCORER_BITERR_EN
                    bes_n   = '0;
`endif
                end
            end

            SWEEP: begin
                if (mismatch) begin
                    err_n = err_q + ECW'(1);
`ifdef MULT_SCORER_BITERR_EN
                    bes_n = bes_q + BEW'(pc);
`endif
                    if (!ffv_q) begin
                        ffv_n = 1'b1;
                        ffa_n = idx[PW-1:N];
                        ffb_n = idx[N-1:0];
                    end
                end
                // Last vector is scored this cycle; operands hold on it afterwards
                if (last_vec) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                end else begin
                    idx_n = idx + PW'(1);
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.a_o              = idx[PW-1:N];
    assign bus.b_o              = idx[N-1:0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_a     = ffa_q;
    assign bus.first_fail_b     = ffb_q;
`ifdef MULT_SCORER_BITERR_EN
    assign bus.bit_err_sum      = bes_q;
`else
    assign bus.bit_err_sum      = '0;
`endif

endmodule
